// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and defaults for the two-port adder arbiter.
// Holds the controller state enum, port-index constants and default sizes.
package adder_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
// Ports: req[1:0] requests, last = last served port, grant[1:0] one-hot.
module rr_pick2
  import adder_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = (last == PORT0) ? 2'b10 : 2'b01;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/adder_arb16.sv
// adder_arb16: shares one external WIDTH-bit adder between two requesters.
// Ports: clk, rst_n (sync, active-low); req_i[1:0] with per-port operands
// a0_i/b0_i/cin0_i and a1_i/b1_i/cin1_i; results done_o[1:0] (one-hot pulse),
// sum_o, cout_o, err_o, busy_o; adder side add_en_o, add_a_o, add_b_o,
// add_cin_o, add_ready_i, add_sum_i, add_cout_i.
// Optional macro ADDARB_TIMEOUT_EN: aborts WAIT after TIMEOUT cycles
// with err_o=1; without it WAIT waits indefinitely and err_o stays 0.
module adder_arb16
  import adder_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic             cin0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic             cin1_i,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             add_en_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_cin_o,
  input  logic             add_ready_i,
  input  logic [WIDTH-1:0] add_sum_i,
  input  logic             add_cout_i
);

  state_t     state;
  logic       last;
  logic       gidx;
  logic [1:0] pick;

  rr_pick2 u_pick (
    .req   (req_i),
    .last  (last),
    .grant (pick)
  );

`ifdef ADDARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;
  logic          expired;
  // last WAIT cycle of the budget: abort on this edge
  assign expired = (tcnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_DRAIN;
      last      <= PORT1;
      gidx      <= PORT0;
      add_en_o  <= 1'b0;
      add_a_o   <= '0;
      add_b_o   <= '0;
      add_cin_o <= 1'b0;
      done_o    <= 2'b00;
      sum_o     <= '0;
      cout_o    <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b1;
`ifdef ADDARB_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      done_o <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (pick != 2'b00) begin
            gidx      <= pick[1] ? PORT1 : PORT0;
            add_a_o   <= pick[1] ? a1_i : a0_i;
            add_b_o   <= pick[1] ? b1_i : b0_i;
            add_cin_o <= pick[1] ? cin1_i : cin0_i;
            add_en_o  <= 1'b1;
            busy_o    <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef ADDARB_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (add_ready_i) begin
            sum_o    <= add_sum_i;
            cout_o   <= add_cout_i;
            err_o    <= 1'b0;
            done_o   <= (gidx == PORT1) ? 2'b10 : 2'b01;
            add_en_o <= 1'b0;
            state    <= S_DONE;
          end
`ifdef ADDARB_TIMEOUT_EN
          else if (expired) begin
            sum_o    <= '0;
            cout_o   <= 1'b0;
            err_o    <= 1'b1;
            done_o   <= (gidx == PORT1) ? 2'b10 : 2'b01;
            add_en_o <= 1'b0;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          last  <= gidx;
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          // a ready still high from the last op must not launch the next
          if (!add_ready_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arb16.sv
// tb_adder_arb16: self-checking bench for adder_arb16 with a behavioural
// adder, a vector table, hand sequences and randomized traffic.
module tb_adder_arb16;
  import adder_arb_pkg::*;

  localparam int W  = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic [1:0]   done;
  logic [W-1:0] sum;
  logic         cout, err, busy, add_en;
  logic [W-1:0] add_a, add_b;
  logic         add_cin;
  logic         add_ready = 1'b0;
  logic [W-1:0] add_sum = '0;
  logic         add_cout = 1'b0;

  adder_arb16 #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .a0_i        (a0),
    .b0_i        (b0),
    .cin0_i      (cin0),
    .a1_i        (a1),
    .b1_i        (b1),
    .cin1_i      (cin1),
    .done_o      (done),
    .sum_o       (sum),
    .cout_o      (cout),
    .err_o       (err),
    .busy_o      (busy),
    .add_en_o    (add_en),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_cin_o   (add_cin),
    .add_ready_i (add_ready),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout)
  );

  // behavioural adder: ready lat cycles after en, held hold cycles after en drops
  int lat = 3;
  int hold = 0;
  bit never = 1'b0;
  int ecnt = 0;
  int hcnt = 0;

  always @(posedge clk) begin
    if (add_en) begin
      ecnt <= ecnt + 1;
      hcnt <= 0;
      if (!never && (ecnt + 1 >= lat)) begin
        add_ready <= 1'b1;
        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
      end
    end else begin
      ecnt <= 0;
      if (add_ready) begin
        if (hcnt >= hold) add_ready <= 1'b0;
        hcnt <= hcnt + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int last_srv = 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[16:0];
  endfunction

  function automatic int exp_port(input logic [1:0] r);
    if (r == 2'b11) return 1 - last_srv;
    if (r[0]) return 0;
    return 1;
  endfunction

  task automatic wait_done(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done pulse within 200 cycles");
    end
  endtask

  task automatic wait_idle(output int cyc);
    int spur;
    bit ok;
    spur = 0;
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (done != 2'b00) spur++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
    chk("no_spurious_done", 32'(spur), 32'd0);
  endtask

  task automatic serve(input string name, output int cyc);
    int p;
    logic [16:0] r;
    bit ok;
    p = exp_port(req);
    r = (p == 0) ? ref_add(a0, b0, cin0) : ref_add(a1, b1, cin1);
    wait_done(cyc, ok);
    if (ok) begin
      chk({name, " done"}, 32'(done), 32'd1 << p);
      chk({name, " sum"}, 32'(sum), 32'(r[15:0]));
      chk({name, " cout"}, 32'(cout), 32'(r[16]));
      chk({name, " err"}, 32'(err), 32'd0);
      last_srv = p;
    end
  endtask

  typedef struct {
    logic [1:0]   rq;
    logic [W-1:0] va0, vb0;
    logic         vc0;
    logic [W-1:0] va1, vb1;
    logic         vc1;
    int           vlat;
    int           vhold;
    logic [1:0]   exp_done;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    int cyc;
    bit ok;
    logic [16:0] r;

    tbl[0] = '{2'b01, 16'd127, 16'd127, 1'b0, 16'd0, 16'd0, 1'b0,
               3, 0, 2'b01, 16'd254, 1'b0};
    tbl[1] = '{2'b10, 16'd0, 16'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0,
               3, 0, 2'b10, 16'h0000, 1'b1};
    tbl[2] = '{2'b10, 16'd0, 16'd0, 1'b0, 16'h00FF, 16'h0000, 1'b1,
               1, 0, 2'b10, 16'h0100, 1'b0};
    tbl[3] = '{2'b11, 16'd1, 16'd2, 1'b0, 16'd5, 16'd6, 1'b1,
               2, 1, 2'b01, 16'd3, 1'b0};
    tbl[4] = '{2'b11, 16'd1, 16'd2, 1'b0, 16'd5, 16'd6, 1'b1,
               4, 0, 2'b10, 16'd12, 1'b0};
    tbl[5] = '{2'b01, 16'h8000, 16'h8000, 1'b1, 16'd0, 16'd0, 1'b0,
               3, 4, 2'b01, 16'h0001, 1'b1};
    tbl[6] = '{2'b11, 16'd9, 16'd9, 1'b0, 16'h1234, 16'h4321, 1'b0,
               2, 2, 2'b10, 16'h5555, 1'b0};

    rst_n = 1'b0;
    req = 2'b00;
    a0 = '0; b0 = '0; cin0 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst add_en", 32'(add_en), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    chk("rst add_a", 32'(add_a), 32'd0);
    chk("rst add_b", 32'(add_b), 32'd0);
    chk("rst add_cin", 32'(add_cin), 32'd0);
    chk("rst busy", 32'(busy), 32'd1);

    rst_n = 1'b1;
    wait_idle(cyc);

    for (int i = 0; i < 7; i++) begin
      a0 = tbl[i].va0; b0 = tbl[i].vb0; cin0 = tbl[i].vc0;
      a1 = tbl[i].va1; b1 = tbl[i].vb1; cin1 = tbl[i].vc1;
      lat = tbl[i].vlat;
      hold = tbl[i].vhold;
      req = tbl[i].rq;
      wait_done(cyc, ok);
      if (ok) begin
        chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].exp_done));
        chk($sformatf("vec%0d sum", i), 32'(sum), 32'(tbl[i].exp_sum));
        chk($sformatf("vec%0d cout", i), 32'(cout), 32'(tbl[i].exp_cout));
        chk($sformatf("vec%0d err", i), 32'(err), 32'd0);
        chk($sformatf("vec%0d latency", i), 32'(cyc), 32'(tbl[i].vlat + 2));
      end
      last_srv = tbl[i].exp_done[1] ? 1 : 0;
      req = 2'b00;
      wait_idle(cyc);
      chk($sformatf("vec%0d drain", i), 32'(cyc), 32'(tbl[i].vhold + 2));
    end

    // fresh reset, then both ports requesting continuously
    lat = 2;
    hold = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_srv = 1;
    wait_idle(cyc);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      serve("alt", cyc);
      chk($sformatf("alt%0d order", k), 32'(done),
          (k % 2 == 0) ? 32'd1 : 32'd2);
      if (last_srv == 0) begin
        a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
      end else begin
        a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
      end
    end
    req = 2'b00;
    wait_idle(cyc);

    // reset while WAIT is pending
    lat = 20;
    a0 = 16'h0F0F; b0 = 16'h00F1; cin0 = 1'b1;
    req = 2'b01;
    for (int i = 0; i < 50 && !add_en; i++) @(negedge clk);
    chk("midrst launched", 32'(add_en), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst add_en", 32'(add_en), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst busy", 32'(busy), 32'd1);
    lat = 2;
    rst_n = 1'b1;
    last_srv = 1;
    serve("midrst reserve", cyc);
    req = 2'b00;
    wait_idle(cyc);

    // randomized traffic against the reference model
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
    for (int it = 0; it < 60; it++) begin
      if (req == 2'b00) req = 2'($urandom_range(1, 3));
      lat = $urandom_range(1, 5);
      hold = $urandom_range(0, 3);
      serve($sformatf("rand%0d", it), cyc);
      if (last_srv == 0) begin
        a0 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
        b0 = W'($urandom);
        cin0 = 1'($urandom);
        req[0] = 1'($urandom);
      end else begin
        a1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
        b1 = W'($urandom);
        cin1 = 1'($urandom);
        req[1] = 1'($urandom);
      end
    end
    req = 2'b00;
    wait_idle(cyc);

`ifdef ADDARB_TIMEOUT_EN
    never = 1'b1;
    a0 = 16'd5; b0 = 16'd6; cin0 = 1'b0;
    req = 2'b01;
    wait_done(cyc, ok);
    if (ok) begin
      chk("timeout done", 32'(done), 32'd1);
      chk("timeout err", 32'(err), 32'd1);
      chk("timeout sum", 32'(sum), 32'd0);
      chk("timeout cout", 32'(cout), 32'd0);
      chk("timeout cycles", 32'(cyc), 32'(TO + 2));
    end
    req = 2'b00;
    never = 1'b0;
    wait_idle(cyc);
    lat = 1;
    a1 = 16'd40; b1 = 16'd2; cin1 = 1'b0;
    req = 2'b10;
    r = ref_add(a1, b1, cin1);
    wait_done(cyc, ok);
    if (ok) begin
      chk("post timeout err", 32'(err), 32'd0);
      chk("post timeout sum", 32'(sum), 32'(r[15:0]));
    end
    req = 2'b00;
    wait_idle(cyc);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
